// File: rtl/reg_dump_pkg.sv
// rtl/reg_dump_pkg.sv - shared types and constants for the register dump engine (REG_DUMP_SKIP_ZR_EN)
package reg_dump_pkg;

    localparam int DATA_W_DEF = 64;
    localparam int NREGS_DEF  = 32;
    localparam int IDX_W_DEF  = $clog2(NREGS_DEF);
    localparam int ZR_IDX     = NREGS_DEF - 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_SEND = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // The zero register sits at the top of the file, so skipping it just pulls the last index down by one.
    function automatic int last_idx(input int nregs);
`ifdef REG_DUMP_SKIP_ZR_EN
        return nregs - 2;
`else
        return nregs - 1;
`endif
    endfunction

endpackage

// File: rtl/reg_dump_if.sv
// rtl/reg_dump_if.sv - register-file read port and dump beat stream bundle
interface reg_dump_if #(
    parameter int DATA_W = 64,
    parameter int IDX_W  = 5
);
    logic              start;
    logic [IDX_W-1:0]  ra;
    logic [DATA_W-1:0] rd;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [IDX_W-1:0]  out_idx;
    logic              busy;
    logic              done;

    modport master (
        input  start, rd, out_ready,
        output ra, out_valid, out_data, out_idx, busy, done
    );

    modport slave (
        output start, rd, out_ready,
        input  ra, out_valid, out_data, out_idx, busy, done
    );
endinterface

// File: rtl/reg_dump_ctr.sv
// rtl/reg_dump_ctr.sv - register index counter with clear, increment and last-index flag
module reg_dump_ctr #(
    parameter int IDX_W = 5,
    parameter int LAST  = 31
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    output logic [IDX_W-1:0] idx,
    output logic             last
);

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            idx <= '0;
        end else if (inc) begin
            idx <= idx + 1'b1;
        end
    end

    assign last = (idx == IDX_W'(LAST));

endmodule

// File: rtl/reg_dump.sv
// rtl/reg_dump.sv - scans the register file and streams one beat per register (REG_DUMP_SKIP_ZR_EN drops the zero register)
module reg_dump
    import reg_dump_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int NREGS  = NREGS_DEF
) (
    input  logic        clk,
    input  logic        reset,
    reg_dump_if.master  bus
);

    localparam int IDX_W = $clog2(NREGS);
    localparam int LAST  = last_idx(NREGS);

    state_t            state_q, state_d;
    logic              ctr_clr, ctr_inc, ctr_last;
    logic [IDX_W-1:0]  idx;
    logic              load_beat, clear_valid;
    logic              valid_q;
    logic [DATA_W-1:0] data_q;
    logic [IDX_W-1:0]  idx_q;

    reg_dump_ctr #(.IDX_W(IDX_W), .LAST(LAST)) u_ctr (
        .clk   (clk),
        .reset (reset),
        .clr   (ctr_clr),
        .inc   (ctr_inc),
        .idx   (idx),
        .last  (ctr_last)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        ctr_clr     = 1'b0;
        ctr_inc     = 1'b0;
        load_beat   = 1'b0;
        clear_valid = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    ctr_clr = 1'b1;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                load_beat = 1'b1;
                state_d   = ST_SEND;
            end
            ST_SEND: begin
                if (valid_q && bus.out_ready) begin
                    clear_valid = 1'b1;
                    if (ctr_last) begin
                        state_d = ST_DONE;
                    end else begin
                        ctr_inc = 1'b1;
                        state_d = ST_LOAD;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // The read port is combinational, so rd is captured in the same cycle ra presents the index.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            idx_q   <= '0;
        end else if (load_beat) begin
            valid_q <= 1'b1;
            data_q  <= bus.rd;
            idx_q   <= idx;
        end else if (clear_valid) begin
            valid_q <= 1'b0;
        end
    end

    assign bus.ra        = idx;
    assign bus.out_valid = valid_q;
    assign bus.out_data  = data_q;
    assign bus.out_idx   = idx_q;
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.done      = (state_q == ST_DONE);

endmodule

// File: doc/reg_dump.md
REG_DUMP -- requirements
Module: reg_dump

Interface
REQ-001 Parameter: DATA_W, 64, width of one register word.
REQ-002 Parameter: NREGS, 32, number of architectural registers scanned; index width is clog2(NREGS).
REQ-003 The block SHALL use one clock and a synchronous, active-high reset.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 reset  in  1  synchronous active-high reset.
REQ-006 start  in  1  request to dump the register file; sampled only in IDLE.
REQ-007 ra  out  5  address driven to the register file's combinational read port.
REQ-008 rd  in  DATA_W  read data returned by the register file for ra, same cycle.
REQ-009 out_valid  out  1  out_data/out_idx hold a valid beat.
REQ-010 out_ready  in  1  consumer accepts the beat when out_valid is also high.
REQ-011 out_data  out  DATA_W  captured register value.
REQ-012 out_idx  out  5  register index of out_data.
REQ-013 busy  out  1  high in every state except IDLE.
REQ-014 done  out  1  single-cycle pulse after the last beat is accepted.

Function
REQ-015 FSM states SHALL be IDLE, LOAD, SEND and DONE.
REQ-016 IDLE: on start=1, clear the index to 0 and go to LOAD; otherwise stay.
REQ-017 LOAD: drive ra=index, capture rd into out_data and index into out_idx, set out_valid, go to SEND.
REQ-018 SEND: hold out_valid, out_data and out_idx stable until out_valid&&out_ready.
REQ-019 On handshake in SEND, if the index equals the last index, clear out_valid and go to DONE; otherwise increment the index, clear out_valid and go to LOAD.
REQ-020 DONE: assert done for exactly one cycle, then return to IDLE.
REQ-021 Outside LOAD, ra SHALL be driven to the current index; its value is don't-care to consumers.
REQ-022 With out_ready held at 1, each register SHALL take 2 cycles.
REQ-023 The first out_valid SHALL occur 2 edges after start is sampled.
REQ-024 done SHALL assert 2*N+1 edges after start is sampled, where N is the number of beats.
REQ-025 start while busy SHALL be ignored and SHALL NOT restart or extend the dump.
REQ-026 out_ready while out_valid=0 SHALL have no effect.
REQ-027 The index SHALL never wrap; the last index terminates the scan.
REQ-028 Register-file writes during a dump SHALL be reflected in a beat only if they occur before that register's LOAD cycle.

Reset
REQ-029 reset SHALL force IDLE and drive busy=0, done=0, out_valid=0, out_data=0, out_idx=0 and index=0 at the next edge.
REQ-030 reset SHALL override all other inputs, including mid-dump and while out_valid=1.
REQ-031 A reset mid-dump SHALL discard the dump, and the next start SHALL begin again at index 0.

Configuration
REQ-032 Macro REG_DUMP_SKIP_ZR_EN.
- Defined: the zero register (index NREGS-1) is not emitted; the last index is NREGS-2 and N=31.
- Undefined: all NREGS registers are emitted; the last index is NREGS-1 and N=32.

Structure
REQ-033 The state enum, DATA_W/NREGS defaults and the zero-register index constant SHALL live in the shared CPU package.
REQ-034 One sub-module, reg_dump_ctr, SHALL be used: an index counter with clear, increment and a last flag.

Verification
REQ-035 Register file in power-up state (regs[i]=i, X31=0), macro undefined, out_ready=1, start pulse: 32 beats carrying out_idx 0..31 and out_data 0..30 then 0; done at edge 65; busy falls with done.
REQ-036 out_ready=0 for 5 cycles on beat 3: out_valid stays 1 and out_data stays 3 throughout; no beat is lost or duplicated.
REQ-037 start re-pulsed at beat 10: the beat stream is unchanged and there is exactly one done.
REQ-038 reset while out_valid=1 at beat 10: out_valid=0 and busy=0 at the next edge; the next start emits out_idx 0 first.
REQ-039 Write 0xDEADBEEF to register 5 before start: beat 5 carries 0xDEADBEEF.
REQ-040 REG_DUMP_SKIP_ZR_EN defined: 31 beats, last out_idx 30, done at edge 63.
